// File: rtl/product_accumulator.sv
// -----------------------------------------------------------------------------
// product_accumulator
//
// Accumulates a stream of signed products into a dot product of VEC_LEN
// elements. Each accepted product is added into a running accumulator. When
// the last product of a vector is accepted, the finished sum is registered
// onto SUM, and outReady pulses for one cycle. Accumulation of the next
// vector can begin on the very next cycle.
//
// Parameters
//   IN_WIDTH  : multiplier operand width (product width is 2*IN_WIDTH)
//   VEC_LEN   : products per dot product (1..1024)
//   ACC_WIDTH : accumulator / result width
//
// Ports
//   clk      in   single clock, rising edge
//   reset    in   asynchronous active-high reset
//   enable   in   global clock enable; all registers hold while low
//   flush    in   synchronous discard of any partial vector
//   inReady  in   qualifies DP as a valid product this cycle
//   DP       in   signed product, 2*IN_WIDTH bits
//   outReady out  one-cycle strobe marking SUM valid
//   SUM      out  signed dot-product result, held until the next result
//   busy     out  high while a partial vector is held
// -----------------------------------------------------------------------------
module product_accumulator #(
    parameter int IN_WIDTH  = 10,
    parameter int VEC_LEN   = 16,
    parameter int ACC_WIDTH = 2*IN_WIDTH + $clog2(VEC_LEN)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          flush,
    input  logic                          inReady,
    input  logic signed [2*IN_WIDTH-1:0]  DP,
    output logic                          outReady,
    output logic signed [ACC_WIDTH-1:0]   SUM,
    output logic                          busy
);

    localparam int PROD_W = 2*IN_WIDTH;
    // A counter of at least one bit keeps the VEC_LEN=1 build legal.
    localparam int CNT_W  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t                         state_q, state_d;
    logic        [CNT_W-1:0]        cnt_q,   cnt_d;
    logic signed [ACC_WIDTH-1:0]    acc_q,   acc_d;
    logic signed [ACC_WIDTH-1:0]    sum_q,   sum_d;
    logic                           rdy_q,   rdy_d;

    logic signed [ACC_WIDTH-1:0]    dp_ext;
    logic                           accept;
    logic                           is_last;

    // Two's complement sign extension of the product to accumulator width.
    function automatic logic signed [ACC_WIDTH-1:0] sext(input logic signed [PROD_W-1:0] v);
        return ACC_WIDTH'(v);
    endfunction

    assign dp_ext  = sext(DP);
    assign accept  = enable && inReady && !flush;
    // With VEC_LEN=1 every product closes a vector.
    assign is_last = (VEC_LEN == 1) || (cnt_q == LAST_CNT);

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        rdy_d   = rdy_q;

        if (enable) begin
            rdy_d = 1'b0;
            if (flush) begin
                acc_d   = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end else if (accept) begin
                if (is_last) begin
                    // IDLE here can only mean VEC_LEN=1: the sum is DP alone.
                    sum_d   = (state_q == IDLE) ? dp_ext : acc_q + dp_ext;
                    rdy_d   = 1'b1;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (state_q == IDLE) begin
                    // First element of a vector loads rather than adds, so a
                    // new vector can start right after a completed one.
                    acc_d   = dp_ext;
                    cnt_d   = CNT_W'(1);
                    state_d = ACCUM;
                end else begin
                    acc_d   = acc_q + dp_ext;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            rdy_q   <= rdy_d;
        end
    end

    assign outReady = rdy_q;
    assign SUM      = sum_q;
    assign busy     = (state_q == ACCUM);

endmodule
